// File: rtl/axil_host_master.sv
// AXI4-Lite single-outstanding master: turns one register command into one
// AXI-Lite write (AW+W concurrently, then B) or read (AR, then R) and returns a response.
module axil_host_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_write,
    output logic              timeout_flag,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);
    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR_DATA, S_WRESP, S_RADDR, S_RDATA, S_RSP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_cmd_ready, r_aw_done, r_w_done;
    logic              r_awvalid, r_wvalid, r_arvalid;
    logic [ADDR_W-1:0] r_awaddr, r_araddr;
    logic [31:0]       r_wdata, r_rsp_rdata;
    logic [3:0]        r_wstrb;
    logic              r_rsp_valid, r_rsp_write, r_timeout;
    logic [1:0]        r_rsp_resp;
    logic [CNT_W-1:0]  r_cnt;

    logic w_accept, w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs, w_busy;

    // r_cmd_ready is only ever high in IDLE, so it doubles as the accept qualifier
    assign w_accept = r_cmd_ready & cmd_valid;
    assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs   = r_wvalid & M_AXI_WREADY;
    assign w_ar_hs  = r_arvalid & M_AXI_ARREADY;
    assign w_b_hs   = (r_state == S_WRESP) & M_AXI_BVALID;
    assign w_r_hs   = (r_state == S_RDATA) & M_AXI_RVALID;
    assign w_busy   = (r_state == S_WADDR_DATA) | (r_state == S_WRESP) |
                      (r_state == S_RADDR) | (r_state == S_RDATA);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:       if (w_accept) w_state_nxt = cmd_write ? S_WADDR_DATA : S_RADDR;
            S_WADDR_DATA: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_nxt = S_WRESP;
            S_WRESP:      if (M_AXI_BVALID) w_state_nxt = S_RSP;
            S_RADDR:      if (w_ar_hs) w_state_nxt = S_RDATA;
            S_RDATA:      if (M_AXI_RVALID) w_state_nxt = S_RSP;
            S_RSP:        if (rsp_ready) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Request channels: VALIDs rise on accept and fall only after their own handshake
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (cmd_write) begin
                    r_awaddr  <= cmd_addr;
                    r_wdata   <= cmd_wdata;
                    r_wstrb   <= cmd_wstrb;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                end else begin
                    r_araddr  <= cmd_addr;
                    r_arvalid <= 1'b1;
                end
            end
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
            if (w_ar_hs) r_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_rsp_write <= 1'b0;
        end else begin
            if (w_b_hs) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= '0;
                r_rsp_resp  <= M_AXI_BRESP;
                r_rsp_write <= 1'b1;
            end else if (w_r_hs) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= M_AXI_RDATA;
                r_rsp_resp  <= M_AXI_RRESP;
                r_rsp_write <= 1'b0;
            end else if ((r_state == S_RSP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Watchdog only flags; the AXI transaction always runs to completion
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_busy && (TIMEOUT != 0) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if ((r_cnt + CNT_W'(1)) == CNT_MAX) r_timeout <= 1'b1;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_write     = r_rsp_write;
    assign timeout_flag  = r_timeout;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = (r_state == S_WRESP);
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = (r_state == S_RDATA);
endmodule

// File: tb/tb_axil_host_master.sv
// Bench for axil_host_master: a cycle-level AXI-Lite slave with a word memory model,
// directed scenarios plus randomized transactions, TIMEOUT reduced to 8.
module tb_axil_host_master;
    localparam int TO = 8;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, timeout_flag;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0, rready;

    int          errs = 0, checks = 0;
    logic [31:0] mem [16];

    always #5 clk = ~clk;

    axil_host_master #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout_flag(timeout_flag),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // All tasks start and end just after a falling edge.
    task automatic issue(input bit wr, input logic [31:0] a, d, input logic [3:0] s, output int waited);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errs++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Hold the response for 'hold' cycles (optionally with the next command pending), then consume it.
    task automatic finish_rsp(input int hold, input bit nxt, input logic [31:0] ed, input logic [1:0] er,
                              input logic ew, input logic et);
        if (nxt) begin cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0; end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== ed || rsp_resp !== er ||
                rsp_write !== ew || timeout_flag !== et) begin
                errs++;
                $display("FAIL rsp_hold[%0d]: valid=%b crdy=%b rdata=%h resp=%0d wr=%b to=%b required 1 0 %h %0d %b %b",
                         i, rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_write, timeout_flag, ed, er, ew, et);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errs++; $display("FAIL rsp_done: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic run_write(input logic [31:0] a, d, input logic [3:0] s, input int awd, wd, bd,
                             input logic [1:0] resp, input int hold, input bit nxt, output int waited);
        int k = 0, awc = 0, wc = 0, bc = 0;
        bit awdn = 0, wdn = 0, bdn = 0;
        issue(1'b1, a, d, s, waited);
        while (1) begin
            checks++;
            if (awvalid !== ~awdn || wvalid !== ~wdn || bready !== (awdn & wdn & ~bdn) || rready !== 1'b0 ||
                arvalid !== 1'b0 || cmd_ready !== 1'b0 || timeout_flag !== (k >= TO) ||
                (awvalid === 1'b1 && awaddr !== a) || (wvalid === 1'b1 && (wdata !== d || wstrb !== s))) begin
                errs++;
                $display("FAIL wr_cycle[%0d]: awv=%b wv=%b brdy=%b rrdy=%b arv=%b crdy=%b to=%b awaddr=%h wdata=%h wstrb=%h required %b %b %b 0 0 0 %b %h %h %h",
                         k, awvalid, wvalid, bready, rready, arvalid, cmd_ready, timeout_flag, awaddr, wdata, wstrb,
                         ~awdn, ~wdn, awdn & wdn & ~bdn, k >= TO, a, d, s);
            end
            if (rsp_valid === 1'b1) break;
            if (k >= 300) begin
                errs++; checks++; $display("FAIL wr_no_rsp: rsp_valid=%b required 1 within 300 cycles", rsp_valid);
                break;
            end
            bvalid = 1'b0;
            if (awdn && wdn && !bdn) begin
                if (bc >= bd) begin
                    bvalid = 1'b1; bresp = resp;
                    if (bready === 1'b1) bdn = 1;
                end
                bc++;
            end
            awready = 1'b0; wready = 1'b0;
            if (!awdn) begin
                if (awc >= awd) begin awready = 1'b1; awdn = 1; end
                awc++;
            end
            if (!wdn) begin
                if (wc >= wd) begin
                    wready = 1'b1; wdn = 1;
                    for (int i = 0; i < 4; i++) if (s[i]) mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
                end
                wc++;
            end
            @(negedge clk);
            k++;
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        checks++;
        if (rsp_write !== 1'b1 || rsp_rdata !== 32'h0 || rsp_resp !== resp) begin
            errs++;
            $display("FAIL wr_rsp: write=%b rdata=%h resp=%0d required 1 00000000 %0d", rsp_write, rsp_rdata, rsp_resp, resp);
        end
        finish_rsp(hold, nxt, 32'h0, resp, 1'b1, k >= TO);
    endtask

    task automatic run_read(input logic [31:0] a, input int ard, rd, input logic [1:0] resp,
                            input int hold, output int waited);
        int k = 0, arc = 0, rc = 0;
        bit ardn = 0, rdn = 0;
        logic [31:0] exp = mem[a[5:2]];
        issue(1'b0, a, 32'h0, 4'h0, waited);
        while (1) begin
            checks++;
            if (arvalid !== ~ardn || rready !== (ardn & ~rdn) || bready !== 1'b0 || awvalid !== 1'b0 ||
                wvalid !== 1'b0 || cmd_ready !== 1'b0 || timeout_flag !== (k >= TO) ||
                (arvalid === 1'b1 && araddr !== a)) begin
                errs++;
                $display("FAIL rd_cycle[%0d]: arv=%b rrdy=%b brdy=%b awv=%b wv=%b crdy=%b to=%b araddr=%h required %b %b 0 0 0 0 %b %h",
                         k, arvalid, rready, bready, awvalid, wvalid, cmd_ready, timeout_flag, araddr,
                         ~ardn, ardn & ~rdn, k >= TO, a);
            end
            if (rsp_valid === 1'b1) break;
            if (k >= 300) begin
                errs++; checks++; $display("FAIL rd_no_rsp: rsp_valid=%b required 1 within 300 cycles", rsp_valid);
                break;
            end
            rvalid = 1'b0;
            if (ardn && !rdn) begin
                if (rc >= rd) begin
                    rvalid = 1'b1; rdata = exp; rresp = resp;
                    if (rready === 1'b1) rdn = 1;
                end
                rc++;
            end
            arready = 1'b0;
            if (!ardn) begin
                if (arc >= ard) begin arready = 1'b1; ardn = 1; end
                arc++;
            end
            @(negedge clk);
            k++;
        end
        arready = 1'b0; rvalid = 1'b0;
        checks++;
        if (rsp_write !== 1'b0 || rsp_rdata !== exp || rsp_resp !== resp) begin
            errs++;
            $display("FAIL rd_rsp: write=%b rdata=%h resp=%0d required 0 %h %0d", rsp_write, rsp_rdata, rsp_resp, exp, resp);
        end
        finish_rsp(hold, 1'b0, exp, resp, 1'b0, k >= TO);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'd0 ||
            rsp_write !== 1'b0 || timeout_flag !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
            bready !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 || awaddr !== 32'h0 ||
            wdata !== 32'h0 || wstrb !== 4'h0 || araddr !== 32'h0) begin
            errs++;
            $display("FAIL reset_state: crdy=%b rspv=%b rdata=%h awv=%b wv=%b brdy=%b arv=%b rrdy=%b awaddr=%h required all zero",
                     cmd_ready, rsp_valid, rsp_rdata, awvalid, wvalid, bready, arvalid, rready, awaddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready); end
    endtask

    task automatic test_write_same_cycle();
        int w;
        run_write(32'h000, 32'h0000_0007, 4'hF, 2, 2, 1, 2'd0, 0, 1'b0, w);
    endtask

    task automatic test_write_w_first();
        int w;
        run_write(32'h000, 32'h0000_0005, 4'hF, 3, 0, 0, 2'd0, 1, 1'b0, w);
    endtask

    task automatic test_read_after_write();
        int w;
        run_write(32'h010, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 2'd0, 0, 1'b0, w);
        run_read(32'h010, 2, 1, 2'd0, 0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        run_write(32'h004, 32'h1234_5678, 4'h5, 0, 0, 0, 2'd0, 5, 1'b1, w);
        run_read(32'h000, 0, 0, 2'd0, 0, w);
        checks++;
        if (w !== 0) begin errs++; $display("FAIL b2b_accept: wait=%0d required 0", w); end
    endtask

    task automatic test_resp_passthrough();
        int w;
        run_write(32'h008, 32'hA5A5_A5A5, 4'hC, 1, 0, 2, 2'd2, 0, 1'b0, w);
        run_read(32'h008, 0, 2, 2'd3, 1, w);
    endtask

    task automatic test_timeout();
        int w;
        run_write(32'h000, 32'h0000_0001, 4'hF, 0, 0, 20, 2'd0, 2, 1'b0, w);
        run_read(32'h000, 1, 0, 2'd0, 0, w);
    endtask

    task automatic test_random();
        int w;
        logic [31:0] a;
        for (int n = 0; n < 24; n++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 1) == 1)
                run_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0, w);
            else
                run_read(a, $urandom_range(0, 3), $urandom_range(0, 4), 2'($urandom_range(0, 3)),
                         $urandom_range(0, 2), w);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        issue(1'b0, 32'h010, 32'h0, 4'h0, w);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1 || arvalid !== 1'b0) begin
            errs++; $display("FAIL mid_rdata: rready=%b arvalid=%b required 1 0", rready, arvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rready !== 1'b0 || arvalid !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 ||
            rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || timeout_flag !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: rrdy=%b arv=%b awv=%b wv=%b brdy=%b rspv=%b crdy=%b required all zero",
                     rready, arvalid, awvalid, wvalid, bready, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rready !== 1'b0) begin
            errs++; $display("FAIL reset_restart: cmd_ready=%b rready=%b required 1 0", cmd_ready, rready);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        test_reset();
        test_write_same_cycle();
        test_write_w_first();
        test_read_after_write();
        test_back_to_back();
        test_resp_passthrough();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
